// File: rtl/dmem_bus_if_pkg.sv
// Shared definitions for the data-memory bus interface: FSM state encodings,
// the all-lanes byte enable and the word-alignment helper.
package dmem_bus_if_pkg;

    // M-side (pipeline-facing) sequencer states
    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_DRAIN = 2'd1,
        M_LOAD  = 2'd2,
        M_DONE  = 2'd3
    } m_state_t;

    // Bus-side sequencer states
    typedef enum logic {
        B_IDLE = 1'b0,
        B_BUSY = 1'b1
    } b_state_t;

    localparam logic [3:0]  BE_ALL          = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Clear the byte offset so the bus only ever sees word addresses
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dmem_bus_if_wbuf_fifo.sv
// Posted-store buffer: DEPTH-entry FIFO of {addr,data,be}. Push and pop may
// happen in the same cycle even when full (the popped slot is reused).
module dmem_bus_if_wbuf_fifo
    import dmem_bus_if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CNT_FULL) || w_do_pop);
    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory interface behind the M stage. Stores are posted into a write
// buffer and acked after one cycle; loads wait for the buffer and the bus to
// go idle, then issue a single read. One bus transaction is outstanding at a
// time.
//
// Bus handshake: bus_req rises with bus_we/bus_addr/bus_wdata/bus_be valid and
// all of them stay constant until the agent returns a one-cycle bus_ack
// (bus_rdata valid in that same cycle for reads). bus_req is low in the cycle
// after bus_ack. A buffered store leaves the buffer only when its bus_ack
// arrives, so the head entry occupies a slot for the whole bus cycle.
module dmem_bus_if
    import dmem_bus_if_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read_M,
    input  logic          mem_write_M,
    input  logic [31:0]   alu_out_M,
    input  logic [31:0]   write_data_M,
    input  logic [3:0]    byte_en_M,
    input  logic          m_advance,
    input  logic          kill_M,
    output logic [31:0]   read_data_M,
    output logic          data_mem_ack,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    output logic [3:0]    bus_be,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata,
    output logic [1:0]    dbg_m_state,
    output logic          dbg_b_state
);

    localparam int EW = AW + 36;

    m_state_t      r_m_state;
    b_state_t      r_b_state;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [AW-1:0] r_ld_addr;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [31:0]   r_bus_wdata;
    logic [3:0]    r_bus_be;

    logic [31:0]   w_addr_aligned;
    logic [AW-1:0] w_addr;
    logic [EW-1:0] w_push_entry;
    logic [EW-1:0] w_head;
    logic [AW-1:0] w_head_addr;
    logic [31:0]   w_head_data;
    logic [3:0]    w_head_be;
    logic          w_full;
    logic          w_empty;
    logic          w_bus_done;
    logic          w_pop;
    logic          w_push;
    logic          w_issue_rd;

    assign w_addr_aligned = word_align(alu_out_M);
    assign w_addr         = w_addr_aligned[AW-1:0];
    assign w_push_entry   = {w_addr, write_data_M, byte_en_M};
    assign w_head_addr    = w_head[EW-1 -: AW];
    assign w_head_data    = w_head[35:4];
    assign w_head_be      = w_head[3:0];

    assign w_bus_done = (r_b_state == B_BUSY) && bus_ack;
    // A write's slot is released by its own bus_ack
    assign w_pop      = w_bus_done && r_bus_we;
    // A store in a full buffer may take the slot freed in the same cycle
    assign w_push     = (r_m_state == M_IDLE) && !kill_M && mem_write_M &&
                        (!w_full || w_pop);
    // Loads never overtake buffered stores: issue only once all are on memory
    assign w_issue_rd = (r_m_state == M_DRAIN) && !kill_M && w_empty &&
                        (r_b_state == B_IDLE);

    dmem_bus_if_wbuf_fifo #(
        .DEPTH (WB_DEPTH),
        .WIDTH (EW)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // M-side sequencer: accepts one M-stage access, returns a registered ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_state <= M_IDLE;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_ld_addr <= '0;
        end else begin
            case (r_m_state)
                M_IDLE: begin
                    if (!kill_M) begin
                        if (mem_write_M) begin
                            if (w_push) begin
                                r_m_state <= M_DONE;
                                r_ack     <= 1'b1;
                            end
                        end else if (mem_read_M) begin
                            r_ld_addr <= w_addr;
                            r_m_state <= M_DRAIN;
                        end
                    end
                end
                M_DRAIN: begin
                    if (kill_M) begin
                        r_m_state <= M_IDLE;
                    end else if (w_issue_rd) begin
                        r_m_state <= M_LOAD;
                    end
                end
                M_LOAD: begin
                    // A killed load lets its bus read finish on its own
                    if (kill_M) begin
                        r_m_state <= M_IDLE;
                    end else if (w_bus_done && !r_bus_we) begin
                        r_rdata   <= bus_rdata;
                        r_ack     <= 1'b1;
                        r_m_state <= M_DONE;
                    end
                end
                M_DONE: begin
                    if (kill_M || m_advance) begin
                        r_ack     <= 1'b0;
                        r_rdata   <= '0;
                        r_m_state <= M_IDLE;
                    end
                end
                default: r_m_state <= M_IDLE;
            endcase
        end
    end

    // Bus-side sequencer: buffer head first, then a pending load read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b_state   <= B_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
        end else begin
            case (r_b_state)
                B_IDLE: begin
                    if (!w_empty) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b1;
                        r_bus_addr  <= w_head_addr;
                        r_bus_wdata <= w_head_data;
                        r_bus_be    <= w_head_be;
                        r_b_state   <= B_BUSY;
                    end else if (w_issue_rd) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= r_ld_addr;
                        r_bus_wdata <= '0;
                        r_bus_be    <= BE_ALL;
                        r_b_state   <= B_BUSY;
                    end
                end
                B_BUSY: begin
                    if (bus_ack) begin
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= '0;
                        r_bus_wdata <= '0;
                        r_bus_be    <= '0;
                        r_b_state   <= B_IDLE;
                    end
                end
                default: r_b_state <= B_IDLE;
            endcase
        end
    end

    assign read_data_M  = r_rdata;
    assign data_mem_ack = r_ack;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_be       = r_bus_be;
    assign dbg_m_state  = r_m_state;
    assign dbg_b_state  = r_b_state;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: a bus agent with its own memory, and a program-order
// reference model (expected bus-write queue plus a word memory) that every
// store and load result is checked against.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read_M = 1'b0;
  logic        mem_write_M = 1'b0;
  logic [31:0] alu_out_M = '0;
  logic [31:0] write_data_M = '0;
  logic [3:0]  byte_en_M = '0;
  logic        m_advance = 1'b0;
  logic        kill_M = 1'b0;
  logic [31:0] read_data_M;
  logic        data_mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  dbg_m_state;
  logic        dbg_b_state;

  int total = 0;
  int bad = 0;

  // reference model: bus writes expected in program order, and memory image
  logic [67:0] exp_q[$];
  logic [31:0] ref_mem [1024];
  // bus agent memory
  logic [31:0] slave_mem [1024];

  int   ack_delay = 1;
  bit   ack_hold = 1'b0;
  int   agent_cnt = 0;
  int   reads_done = 0;
  int   writes_done = 0;
  int   req_cycles = 0;
  bit   stab_valid = 1'b0;
  logic [68:0] stab_fields;

  dmem_bus_if #(.WB_DEPTH(4), .AW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_M   (mem_read_M),
    .mem_write_M  (mem_write_M),
    .alu_out_M    (alu_out_M),
    .write_data_M (write_data_M),
    .byte_en_M    (byte_en_M),
    .m_advance    (m_advance),
    .kill_M       (kill_M),
    .read_data_M  (read_data_M),
    .data_mem_ack (data_mem_ack),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .dbg_m_state  (dbg_m_state),
    .dbg_b_state  (dbg_b_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- bus agent ----------------
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      bus_ack = 1'b0;
      agent_cnt = 0;
      stab_valid = 1'b0;
    end else if (bus_ack) begin
      bus_ack = 1'b0;
      bus_rdata = $urandom;
    end else if (bus_req) begin
      req_cycles++;
      if (!stab_valid) begin
        stab_fields = {bus_we, bus_addr, bus_wdata, bus_be};
        stab_valid = 1'b1;
      end else begin
        total++;
        if ({bus_we, bus_addr, bus_wdata, bus_be} !== stab_fields) begin
          bad++;
          $display("FAIL bus_stable: got %h want %h", {bus_we, bus_addr, bus_wdata, bus_be}, stab_fields);
        end
      end
      if (ack_hold) begin
        agent_cnt = 0;
      end else begin
        agent_cnt++;
        if (agent_cnt >= ack_delay) begin
          agent_cnt = 0;
          stab_valid = 1'b0;
          bus_ack = 1'b1;
          if (bus_we) begin
            slave_mem[bus_addr[11:2]] = merge_be(slave_mem[bus_addr[11:2]], bus_wdata, bus_be);
            writes_done++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL bus_write_order: got unexpected write %h/%h/%h, want none", bus_addr, bus_wdata, bus_be);
            end else begin
              logic [67:0] e;
              e = exp_q.pop_front();
              if ({bus_addr, bus_wdata, bus_be} !== e) begin
                bad++;
                $display("FAIL bus_write_order: got %h/%h/%h want %h/%h/%h",
                         bus_addr, bus_wdata, bus_be, e[67:36], e[35:4], e[3:0]);
              end
            end
          end else begin
            bus_rdata = slave_mem[bus_addr[11:2]];
            reads_done++;
            total++;
            if (exp_q.size() != 0 || bus_be !== 4'hF) begin
              bad++;
              $display("FAIL read_order: read issued with %0d stores pending, be=%h (want 0, F)", exp_q.size(), bus_be);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_write_M = 1'b1;
    mem_read_M = 1'b0;
    alu_out_M = a;
    write_data_M = d;
    byte_en_M = be;
    exp_q.push_back({a[31:2], 2'b00, d, be});
    ref_mem[a[11:2]] = merge_be(ref_mem[a[11:2]], d, be);
  endtask

  task automatic start_load(input logic [31:0] a);
    mem_read_M = 1'b1;
    mem_write_M = 1'b0;
    alu_out_M = a;
    byte_en_M = 4'($urandom);
  endtask

  task automatic wait_ack(input int budget, output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      lat++;
      if (data_mem_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op();
    mem_write_M = 1'b0;
    mem_read_M = 1'b0;
    m_advance = 1'b1;
    step();
    m_advance = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && !bus_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({read_data_M, data_mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be, dbg_m_state, dbg_b_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b req=%b addr=%h rdata=%h mst=%0d bst=%0d, want all 0",
               data_mem_ack, bus_req, bus_addr, read_data_M, dbg_m_state, dbg_b_state);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_store();
    int lat;
    bit ok;
    int w0;
    ack_delay = 3;
    w0 = writes_done;
    start_store(32'h100, 32'hDEADBEEF, 4'hF);
    wait_ack(10, lat, ok);
    total++;
    if (!ok || lat != 1) begin
      bad++;
      $display("FAIL store_latency: got ok=%0d lat=%0d want lat=1", ok, lat);
    end
    total++;
    if (bus_req !== 1'b0) begin
      bad++;
      $display("FAIL store_bus_after_ack: bus_req=%b at ack, want 0", bus_req);
    end
    finish_op();
    wait_drain(50, ok);
    total++;
    if (!ok || writes_done != w0 + 1) begin
      bad++;
      $display("FAIL store_drain: ok=%0d writes=%0d want 1", ok, writes_done - w0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    int w0;
    int n_ack;
    ack_hold = 1'b1;
    ack_delay = 1;
    w0 = writes_done;
    for (int i = 0; i < 4; i++) begin
      start_store(32'h500 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)));
      wait_ack(5, lat, ok);
      total++;
      if (!ok || lat != 1) begin
        bad++;
        $display("FAIL b2b_store%0d_latency: got ok=%0d lat=%0d want lat=1", i, ok, lat);
      end
      finish_op();
    end
    start_store(32'h510, $urandom, 4'hF);
    n_ack = 0;
    repeat (6) begin
      step();
      if (data_mem_ack) n_ack++;
    end
    total++;
    if (n_ack != 0) begin
      bad++;
      $display("FAIL b2b_fifth_stall: got %0d ack cycles want 0", n_ack);
    end
    ack_hold = 1'b0;
    wait_ack(10, lat, ok);
    total++;
    if (!ok || writes_done != w0 + 1) begin
      bad++;
      $display("FAIL b2b_fifth_ack: ok=%0d writes_done=%0d want ok=1 writes=1", ok, writes_done - w0);
    end
    finish_op();
    wait_drain(100, ok);
    total++;
    if (!ok || writes_done != w0 + 5) begin
      bad++;
      $display("FAIL b2b_drain: ok=%0d writes=%0d want 5", ok, writes_done - w0);
    end
  endtask

  task automatic test_store_load();
    int lat;
    bit ok;
    ack_delay = 2;
    start_store(32'h200, 32'h11223344, 4'hF);
    wait_ack(10, lat, ok);
    finish_op();
    start_load(32'h202);
    wait_ack(60, lat, ok);
    total++;
    if (!ok || read_data_M !== ref_mem[32'h200 >> 2]) begin
      bad++;
      $display("FAIL store_load_data: ok=%0d got %h want %h", ok, read_data_M, ref_mem[32'h200 >> 2]);
    end
    finish_op();
  endtask

  task automatic test_load_hold();
    int lat;
    bit ok;
    bit held;
    logic [31:0] v;
    v = $urandom;
    slave_mem[32'h300 >> 2] = v;
    ref_mem[32'h300 >> 2] = v;
    ack_delay = 1;
    start_load(32'h300);
    wait_ack(40, lat, ok);
    total++;
    if (!ok || read_data_M !== v) begin
      bad++;
      $display("FAIL hold_load_data: ok=%0d got %h want %h", ok, read_data_M, v);
    end
    mem_read_M = 1'b0;
    held = 1'b1;
    repeat (3) begin
      step();
      if (!data_mem_ack || read_data_M !== v) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL hold_stable: ack=%b data=%h want ack=1 data=%h", data_mem_ack, read_data_M, v);
    end
    m_advance = 1'b1;
    step();
    m_advance = 1'b0;
    total++;
    if (data_mem_ack !== 1'b0) begin
      bad++;
      $display("FAIL hold_ack_drop: ack=%b want 0", data_mem_ack);
    end
  endtask

  task automatic test_kill_load();
    int lat;
    bit ok;
    int r0;
    int n_ack;
    ack_delay = 4;
    r0 = reads_done;
    start_load(32'h400);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_req && !bus_we) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL kill_read_issue: no bus read within 20 cycles, want one");
    end
    kill_M = 1'b1;
    mem_read_M = 1'b0;
    step();
    kill_M = 1'b0;
    n_ack = 0;
    repeat (10) begin
      step();
      if (data_mem_ack) n_ack++;
    end
    total++;
    if (n_ack != 0 || reads_done != r0 + 1) begin
      bad++;
      $display("FAIL kill_no_ack: ack cycles=%0d reads=%0d want 0 and 1", n_ack, reads_done - r0);
    end
    start_store(32'h404, 32'hCAFEF00D, 4'h3);
    wait_ack(10, lat, ok);
    total++;
    if (!ok || lat != 1) begin
      bad++;
      $display("FAIL kill_next_store: ok=%0d lat=%0d want lat=1", ok, lat);
    end
    finish_op();
    wait_drain(50, ok);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    int r0;
    ack_hold = 1'b1;
    ack_delay = 1;
    start_store(32'h600, 32'h0BADF00D, 4'hF);
    wait_ack(5, lat, ok);
    finish_op();
    start_store(32'h604, 32'h12345678, 4'hF);
    wait_ack(5, lat, ok);
    finish_op();
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_setup: bus_req=%b want 1", bus_req);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({read_data_M, data_mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: req=%b we=%b addr=%h wdata=%h be=%h ack=%b, want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_be, data_mem_ack);
    end
    // the abandoned stores never reach memory: drop them from the model
    exp_q.delete();
    ref_mem[32'h600 >> 2] = slave_mem[32'h600 >> 2];
    ref_mem[32'h604 >> 2] = slave_mem[32'h604 >> 2];
    step();
    step();
    ack_hold = 1'b0;
    reset = 1'b1;
    r0 = req_cycles;
    repeat (10) step();
    total++;
    if (req_cycles != r0 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_empty: bus request cycles=%0d after release, want 0", req_cycles - r0);
    end
    start_store(32'h608, 32'h55AA33CC, 4'hF);
    wait_ack(10, lat, ok);
    finish_op();
    start_load(32'h608);
    wait_ack(60, lat, ok);
    total++;
    if (!ok || read_data_M !== ref_mem[32'h608 >> 2]) begin
      bad++;
      $display("FAIL reset_mid_recover: ok=%0d got %h want %h", ok, read_data_M, ref_mem[32'h608 >> 2]);
    end
    finish_op();
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(1, 4);
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        start_store(a, $urandom, 4'($urandom_range(1, 15)));
        wait_ack(60, lat, ok);
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL rand_store_ack: op %0d addr %h no ack within 60 cycles", n, a);
        end
      end else begin
        start_load(a);
        wait_ack(200, lat, ok);
        total++;
        if (!ok || read_data_M !== ref_mem[a[11:2]]) begin
          bad++;
          $display("FAIL rand_load_data: op %0d addr %h ok=%0d got %h want %h", n, a, ok, read_data_M, ref_mem[a[11:2]]);
        end
        mem_read_M = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
      finish_op();
    end
    wait_drain(300, ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: %0d stores left, want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = '0;
      slave_mem[i] = '0;
    end
    test_reset();
    test_single_store();
    test_back_to_back();
    test_store_load();
    test_load_hold();
    test_kill_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
